// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FSM state type, skid-buffer depth and default widths for the FIFO read streamer
package fifo_pkg;
  localparam int SKID_DEPTH     = 2;
  localparam int OCC_W          = $clog2(SKID_DEPTH + 1);
  localparam int PTR_W          = $clog2(SKID_DEPTH);
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CNT_WIDTH  = 16;
  typedef enum logic {RUN, FLUSH} state_e;
endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO read port (empty/rd_en/data_out) plus output stream handshake (m_valid/m_ready/m_data)
// master: the streamer side; slave: the FIFO plus downstream consumer side
interface fifo_rd_stream_if import fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  empty;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  modport master (input empty, data_out, m_ready, output rd_en, m_valid, m_data);
  modport slave (output empty, data_out, m_ready, input rd_en, m_valid, m_data);
endinterface

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: 2-entry FIFO; simultaneous push and pop keep order and occupancy, clr empties it
// ports: rd_clk, rd_rst_n (sync, active-low), clr, push/din (tail write), pop/dout (head), occ
module fifo_skid_buf import fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [OCC_W-1:0]      occ
);
  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = din;
    wr_ptr_d = clr ? '0 : wr_ptr_q + PTR_W'(push);
    rd_ptr_d = clr ? '0 : rd_ptr_q + PTR_W'(pop);
    occ_d    = clr ? '0 : occ_q + OCC_W'(push) - OCC_W'(pop);
  end
  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end
  assign dout = mem_q[rd_ptr_q];
  assign occ  = occ_q;
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns a 1-cycle-latency FIFO read port into a valid/ready stream with flush
// ports: rd_clk, rd_rst_n (sync, active-low), flush, bus (FIFO read + stream), word_cnt, busy (in FLUSH)
module fifo_rd_stream import fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst_n,
  input  logic                 flush,
  fifo_rd_stream_if.master     bus,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic                 busy
);
  localparam int LVL_W = OCC_W + 1;
  state_e                state_q, state_d;
  logic                  infl_q, infl_d, rdy_q, rdy_d, pop, clr, rd_en;
  logic [OCC_W-1:0]      occ;
  logic [LVL_W-1:0]      lvl;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] head;
  fifo_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .rd_clk  (rd_clk),
    .rd_rst_n(rd_rst_n),
    .clr     (clr),
    .push    (infl_q),
    .pop     (pop),
    .din     (bus.data_out),
    .dout    (head),
    .occ     (occ)
  );
  // lvl counts stored plus in-flight words after this cycle's pop, so a read is only issued when it has a slot
  // rdy_q holds off reads for one cycle after reset is released
  always_comb begin
    pop     = (occ != '0) && bus.m_ready;
    lvl     = LVL_W'(occ) + LVL_W'(infl_q) - LVL_W'(pop);
    rd_en   = rdy_q && state_q == RUN && !bus.empty && lvl < LVL_W'(SKID_DEPTH);
    clr     = flush || state_q == FLUSH;
    infl_d  = rd_en;
    rdy_d   = 1'b1;
    state_d = (flush || (state_q == FLUSH && infl_q)) ? FLUSH : RUN;
    cnt_d   = cnt_q + CNT_WIDTH'(pop);
  end
  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      state_q <= RUN;
      infl_q  <= 1'b0;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      infl_q  <= infl_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.rd_en   = rd_en;
  assign bus.m_valid = occ != '0;
  assign bus.m_data  = head;
  assign word_cnt    = cnt_q;
  assign busy        = state_q == FLUSH;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed scenarios with a FIFO model, scoreboard queue and decoupled output monitor
module tb_fifo_rd_stream;
  logic        rd_clk = 1'b0;
  logic        rd_rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] word_cnt;
  logic        busy;
  logic [7:0]  fq[$];
  logic [7:0]  exp_q[$];
  int          pop_t[$];
  int          checks = 0, failures = 0, viol = 0, rd_cnt = 0, cyc = 0;
  int          r0, p0;
  bit          tog_en = 1'b0, blk = 1'b0, pend;

  fifo_rd_stream_if #(.DATA_WIDTH(8)) bus ();
  fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .rd_clk  (rd_clk),
    .rd_rst_n(rd_rst_n),
    .flush   (flush),
    .bus     (bus),
    .word_cnt(word_cnt),
    .busy    (busy)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic put(input logic [7:0] w, input bit keep);
    fq.push_back(w);
    if (keep) exp_q.push_back(w);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge rd_clk);
      n++;
    end
    chk("drain_done", exp_q.size() == 0, 1);
    repeat (3) @(negedge rd_clk);
  endtask

  // FIFO model: read data appears one cycle after rd_en is sampled; empty optionally forced high on alternate cycles
  initial begin
    bus.empty = 1'b1;
    bus.data_out = '0;
    forever begin
      @(posedge rd_clk);
      pend = bus.rd_en;
      cyc++;
      #1;
      if (pend) begin
        rd_cnt++;
        if (fq.size() != 0) bus.data_out = fq.pop_front();
      end
      blk = tog_en ? ~blk : 1'b0;
      bus.empty = (fq.size() == 0) || blk;
    end
  end

  // monitor: a handshake seen here is the pop the DUT takes at the next rising edge
  initial forever begin
    @(negedge rd_clk);
    #1;
    if (bus.rd_en && bus.empty) viol++;
    if (bus.m_valid && bus.m_ready) begin
      pop_t.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word got=%0h expected=none", bus.m_data);
      end else chk("m_data", bus.m_data, exp_q.pop_front());
    end
  end

  initial begin
    bus.m_ready = 1'b0;
    repeat (2) @(negedge rd_clk);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_busy", busy, 0);
    rd_rst_n = 1'b1;
    @(negedge rd_clk);
    // three words, back to back
    p0 = pop_t.size();
    bus.m_ready = 1'b1;
    put(8'h11, 1); put(8'h22, 1); put(8'h33, 1);
    drain(20);
    chk("s1_word_cnt", word_cnt, 3);
    chk("s1_consecutive", pop_t[p0+2] - pop_t[p0], 2);
    chk("s1_no_rd_while_empty", viol, 0);
    // backpressure: only two reads, head held
    bus.m_ready = 1'b0;
    r0 = rd_cnt;
    put(8'h11, 1); put(8'h22, 1); put(8'h33, 1); put(8'h44, 1); put(8'h55, 1);
    repeat (8) @(negedge rd_clk);
    chk("s2_rd_pulses", rd_cnt - r0, 2);
    chk("s2_m_valid", bus.m_valid, 1);
    chk("s2_hold", bus.m_data, 8'h11);
    repeat (3) @(negedge rd_clk);
    chk("s2_hold_later", bus.m_data, 8'h11);
    chk("s2_rd_pulses_later", rd_cnt - r0, 2);
    bus.m_ready = 1'b1;
    drain(30);
    chk("s2_word_cnt", word_cnt, 8);
    // flush with a full buffer and nothing in flight
    bus.m_ready = 1'b0;
    put(8'hA1, 0); put(8'hA2, 0); put(8'hA3, 1); put(8'hA4, 1); put(8'hA5, 1); put(8'hA6, 1);
    repeat (8) @(negedge rd_clk);
    chk("s3_full_valid", bus.m_valid, 1);
    chk("s3_full_no_rd", bus.rd_en, 0);
    flush = 1'b1;
    @(negedge rd_clk);
    flush = 1'b0;
    chk("s3_busy", busy, 1);
    chk("s3_valid_low", bus.m_valid, 0);
    chk("s3_rd_low", bus.rd_en, 0);
    @(negedge rd_clk);
    chk("s3_busy_clear", busy, 0);
    bus.m_ready = 1'b1;
    drain(30);
    chk("s3_word_cnt", word_cnt, 12);
    // flush mid-stream, coinciding with a pop and a read in flight
    put(8'hD1, 1); put(8'hD2, 1); put(8'hD3, 0); put(8'hD4, 0); put(8'hD5, 1); put(8'hD6, 1);
    repeat (4) @(negedge rd_clk);
    flush = 1'b1;
    @(negedge rd_clk);
    flush = 1'b0;
    chk("s4_busy", busy, 1);
    chk("s4_valid_low", bus.m_valid, 0);
    @(negedge rd_clk);
    chk("s4_busy_infl", busy, 1);
    @(negedge rd_clk);
    chk("s4_busy_clear", busy, 0);
    drain(30);
    chk("s4_word_cnt", word_cnt, 16);
    // empty toggling every cycle
    tog_en = 1'b1;
    for (int i = 0; i < 8; i++) put(8'hC0 + 8'(i), 1);
    drain(60);
    tog_en = 1'b0;
    chk("s5_no_rd_while_empty", viol, 0);
    chk("s5_word_cnt", word_cnt, 24);
    // one-cycle reset mid-burst
    put(8'hB1, 1); put(8'hB2, 0); put(8'hB3, 0);
    for (int i = 4; i <= 8; i++) put(8'hB0 + 8'(i), 1);
    repeat (4) @(negedge rd_clk);
    rd_rst_n = 1'b0;
    bus.m_ready = 1'b0;
    @(negedge rd_clk);
    chk("s6_rd_en", bus.rd_en, 0);
    chk("s6_m_valid", bus.m_valid, 0);
    chk("s6_m_data", bus.m_data, 0);
    chk("s6_word_cnt", word_cnt, 0);
    chk("s6_busy", busy, 0);
    rd_rst_n = 1'b1;
    bus.m_ready = 1'b1;
    drain(30);
    chk("s6_word_cnt_after", word_cnt, 5);
    // counter wrap
    rd_rst_n = 1'b0;
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
    chk("s7_cnt_cleared", word_cnt, 0);
    for (int i = 0; i < 65535; i++) put(8'(i), 1);
    drain(70000);
    chk("s7_cnt_max", word_cnt, 16'hFFFF);
    put(8'h5A, 1);
    drain(20);
    chk("s7_cnt_wrap", word_cnt, 16'h0000);
    chk("final_no_rd_while_empty", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
